imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the 16-bit pipelined MIPS core. Fetch only reads instruction memory; this block fills it. It receives a byte stream over a valid/ready handshake and writes 16-bit words to consecutive even byte addresses, matching Fetch's PC+2 stepping. It holds the core stalled via `core_hold` until the image is complete.

## Interface
Parameters:
- `DEPTH_WORDS`, default 256: instruction memory capacity in 16-bit words.
- `BASE_ADDR`, default 16'h0000: byte address of the first word. Must be even.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load. Sampled only in IDLE, DONE and ERR.
- `in_valid` in 1: a byte is presented on `in_data`.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: one-cycle write strobe to instruction memory.
- `imem_addr` out 16: byte address of the write.
- `imem_wdata` out 16: instruction word.
- `core_hold` out 1: stalls the pipeline and PC.
- `done` out 1: image loaded.
- `error` out 1: length rejected.

## Operation
- Stream format:
  - 2-byte big-endian word count N.
  - Then N words, each sent high byte first.
- A byte is accepted on any edge where `in_valid && in_ready`. `in_ready` is a function of state only. It never depends on `in_valid`.
- States and transitions:
  - IDLE: `in_ready`=0. `start` → LEN_HI.
  - LEN_HI: on accept, latch N[15:8] → LEN_LO.
  - LEN_LO: on accept, latch N[7:0].
    - If N==0 → FIN.
    - If N>DEPTH_WORDS → ERR.
    - Otherwise load `words_left`=N and `addr_cnt`=BASE_ADDR → DAT_HI.
  - DAT_HI: on accept, latch the high byte → DAT_LO.
  - DAT_LO: on accept, register the write:
    - `imem_wdata`={hi, byte}, `imem_addr`=`addr_cnt`, `imem_we`=1 next cycle.
    - `addr_cnt`+=2 and `words_left`-=1.
    - Go to FIN if `words_left` was 1, else DAT_HI.
  - FIN: `in_ready`=0, one cycle → DONE.
  - DONE: `done`=1, `core_hold`=0. `start` → LEN_HI, clearing `done` and reasserting `core_hold`.
  - ERR: `error`=1, `in_ready`=0, `core_hold`=1. `start` → LEN_HI and clears `error`.
- `in_ready`=1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO.
- `core_hold`=1 in every state except DONE.
- Arithmetic:
  - `addr_cnt` is 16-bit and wraps modulo 2^16. Wrap is legal. Memory sizing is the integrator's concern.
  - `words_left` is 16-bit.
  - The N>DEPTH_WORDS compare is unsigned, 17-bit safe.
- `in_valid` while `in_ready`=0 is ignored; no byte is consumed.
- `start` in any state other than IDLE, DONE or ERR is ignored.

## Timing
- Reset values (asynchronous):
  - State IDLE.
  - `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_hold`=1, `done`=0, `error`=0.
  - Internal counters 0.
- Throughput: one byte per cycle when `in_valid` is held high, so one word per 2 cycles.
- Latency: the low byte is accepted at edge k. `imem_we`=1 for exactly cycle k+1, with `imem_addr` and `imem_wdata` stable that cycle.
- `imem_addr` and `imem_wdata` hold their last values while `imem_we`=0.
- Final word accepted at edge k:
  - `imem_we` is high in cycle k+1 (FIN).
  - `done`=1 and `core_hold`=0 from cycle k+2.
- N==0 with its last length byte at edge k: no write, `done` from cycle k+2.
- Error: ERR is entered at the edge after LEN_LO is accepted. `error` rises the following cycle. No `imem_we` is ever issued for a rejected image.
- Reset mid-load:
  - Immediately returns to IDLE with all reset values.
  - A pending `imem_we` is dropped.
  - Memory contents already written are left as-is.

## Structure
- Package `imem_loader_pkg` holds:
  - The state enum: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, FIN, DONE, ERR.
  - `WORD_W`=16, `BYTE_W`=8, `ADDR_STEP`=2.
- Single flat module with no sub-modules. The byte-pair assembly is two registers inside the FSM.
- At top level:
  - `imem_we`, `imem_addr` and `imem_wdata` drive a write port added to the Fetch instruction memory.
  - `core_hold` gates the PC update and the IF_ID register.

## Test plan
- Reset, then `start`, then stream 00 03 12 34 56 78 9A BC with `in_valid` held high. Expect:
  - Writes 1234@0000, 5678@0002 and 9ABC@0004, each `imem_we` one cycle long and 2 cycles apart.
  - `done`=1 and `core_hold`=0 two cycles after the last byte.
- Same image with `in_valid` toggling 1,0,1,0. Expect identical writes and data, no duplicate or missing bytes, and `in_ready` unaffected by `in_valid`.
- Stream 00 00. Expect no `imem_we`, and `done`=1 two cycles after the second byte.
- With `DEPTH_WORDS`=256, stream 01 01. Expect:
  - `error`=1 and `core_hold`=1.
  - `in_ready`=0 and extra bytes ignored.
  - `start` then clears `error` and a valid image loads correctly.
- Assert `rst_n`=0 after the high byte of word 2. Expect all outputs at reset values asynchronously and no write of word 2. A fresh `start` with a new image writes from `BASE_ADDR`.
- From DONE, `start` a second 1-word image AAAA. Expect `done` to drop and `core_hold` to rise the cycle after `start`, then AAAA written at 0000.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Boot-time instruction-memory writer package.
package imem_loader_pkg;

    localparam int          WORD_W    = 16;
    localparam int          BYTE_W    = 8;
    localparam logic [15:0] ADDR_STEP = 16'd2;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DAT_HI,
        DAT_LO,
        FIN,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream in, 16-bit instruction words out.
// Keeps the core held until a complete image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [15:0] BASE_ADDR   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [15:0]       imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [BYTE_W-1:0] len_hi_q;
    logic [BYTE_W-1:0] hi_q;
    logic [15:0]       words_left;
    logic [15:0]       addr_cnt;
    logic [15:0]       len_n;
    logic              len_zero;
    logic              too_long;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    assign len_n     = {len_hi_q, in_data};
    assign len_zero  = (len_n == 16'd0);
    assign too_long  = ({1'b0, len_n} > DEPTH_LIM);
    assign last_word = (words_left == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_nxt = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_zero)      state_nxt = FIN;
                    else if (too_long) state_nxt = ERR;
                    else               state_nxt = DAT_HI;
                end
            end
            DAT_HI: begin
                if (accept) state_nxt = DAT_LO;
            end
            DAT_LO: begin
                if (accept) begin
                    state_nxt = last_word ? FIN : DAT_HI;
                end
            end
            FIN: begin
                state_nxt = DONE;
            end
            DONE, ERR: begin
                if (start) state_nxt = LEN_HI;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake and status are pure state decodes; in_valid never feeds in_ready.
    always_comb begin
        in_ready  = 1'b0;
        core_hold = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        unique case (state)
            LEN_HI, LEN_LO, DAT_HI, DAT_LO: begin
                in_ready = 1'b1;
            end
            DONE: begin
                core_hold = 1'b0;
                done      = 1'b1;
            end
            ERR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi_q   <= '0;
            hi_q       <= '0;
            words_left <= '0;
            addr_cnt   <= '0;
        end else if (accept) begin
            unique case (state)
                LEN_HI: begin
                    len_hi_q <= in_data;
                end
                LEN_LO: begin
                    words_left <= len_n;
                    addr_cnt   <= BASE_ADDR;
                end
                DAT_HI: begin
                    hi_q <= in_data;
                end
                DAT_LO: begin
                    words_left <= words_left - 16'd1;
                    addr_cnt   <= addr_cnt + ADDR_STEP;
                end
                default: begin
                end
            endcase
        end
    end

    // Write port: one-cycle strobe, address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= accept && (state == DAT_LO);
            if (accept && (state == DAT_LO)) begin
                imem_addr  <= addr_cnt;
                imem_wdata <= {hi_q, in_data};
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Expected writes come from a byte-level image model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;

    localparam int          DEPTH = 256;
    localparam logic [15:0] BASE  = 16'h0000;

    imem_loader #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  img[$];

    bit          chk_spacing = 1'b0;
    int          wr_idx = 0;
    int          last_we_cyc = 0;
    logic [15:0] last_addr = 16'h0;
    logic [15:0] last_data = 16'h0;
    bit          prev_we = 1'b0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Image model: header gives N; each word lands at BASE + 2*i.
    task automatic build_exp(input logic [7:0] b[$]);
        logic [15:0] n;
        logic [15:0] a;
        n = {b[0], b[1]};
        exp_q.delete();
        if (n != 16'd0 && int'(n) <= DEPTH) begin
            for (int i = 0; i < int'(n); i++) begin
                a = BASE + 16'(2 * i);
                exp_q.push_back({a, b[2 + 2 * i], b[3 + 2 * i]});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("hold_vs_done", {31'b0, core_hold}, {31'b0, ~done});
            if (imem_we) begin
                chk("we_single_cycle", {31'b0, prev_we}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_write: got %h@%h expected none",
                             imem_wdata, imem_addr);
                end else begin
                    chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
                end
                if (chk_spacing && wr_idx > 0)
                    chk("write_spacing", cyc - last_we_cyc, 32'd2);
                wr_idx++;
                last_we_cyc = cyc;
                last_addr = imem_addr;
                last_data = imem_wdata;
            end
            prev_we = imem_we;
        end else begin
            prev_we = 1'b0;
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns right after the edge that accepts the final byte.
    task automatic send(input logic [7:0] b[$], input bit toggle);
        int idx = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit acc;
        while (idx < b.size() && guard < 100) begin
            @(negedge clk);
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            in_data = b[idx];
            #1;
            chk("in_ready_streaming", {31'b0, in_ready}, 32'd1);
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            guard++;
        end
        if (idx < b.size()) begin
            checks++;
            $display("FAIL send_timeout: got %0d bytes expected %0d",
                     idx, b.size());
        end
    endtask

    task automatic finish_img(input bit exp_we);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("we_after_last", {31'b0, imem_we}, {31'b0, exp_we});
        chk("done_k1", {31'b0, done}, 32'd0);
        @(negedge clk);
        #1;
        chk("done_k2", {31'b0, done}, 32'd1);
        chk("hold_k2", {31'b0, core_hold}, 32'd0);
        chk("error_k2", {31'b0, error}, 32'd0);
        chk("missing_writes", exp_q.size(), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        chk({tag, "_we"}, {31'b0, imem_we}, 32'd0);
        chk({tag, "_addr"}, {16'b0, imem_addr}, 32'd0);
        chk({tag, "_wdata"}, {16'b0, imem_wdata}, 32'd0);
        chk({tag, "_hold"}, {31'b0, core_hold}, 32'd1);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_error"}, {31'b0, error}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Image 1, in_valid held high.
        img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        build_exp(img);
        chk("model_len", exp_q.size(), 32'd3);
        chk_spacing = 1'b1;
        wr_idx = 0;
        do_start();
        send(img, 1'b0);
        finish_img(1'b1);
        chk("img1_last_addr", {16'b0, last_addr}, 32'h0004);
        chk("img1_last_data", {16'b0, last_data}, 32'h9ABC);
        chk("img1_count", wr_idx, 32'd3);

        // Same image, in_valid toggling.
        chk_spacing = 1'b0;
        wr_idx = 0;
        build_exp(img);
        do_start();
        #1;
        chk("restart_done", {31'b0, done}, 32'd0);
        chk("restart_hold", {31'b0, core_hold}, 32'd1);
        send(img, 1'b1);
        finish_img(1'b1);
        chk("img2_count", wr_idx, 32'd3);
        chk("img2_last_data", {16'b0, last_data}, 32'h9ABC);

        // Empty image.
        img = '{8'h00, 8'h00};
        build_exp(img);
        wr_idx = 0;
        do_start();
        send(img, 1'b0);
        finish_img(1'b0);
        chk("empty_count", wr_idx, 32'd0);

        // Oversized image rejected.
        img = '{8'h01, 8'h01};
        build_exp(img);
        do_start();
        send(img, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("err_flag", {31'b0, error}, 32'd1);
        chk("err_hold", {31'b0, core_hold}, 32'd1);
        chk("err_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data = 8'h77;
        repeat (4) @(negedge clk);
        #1;
        chk("err_sticky", {31'b0, error}, 32'd1);
        chk("err_ready2", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0;
        do_start();
        #1;
        chk("err_cleared", {31'b0, error}, 32'd0);
        img = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_exp(img);
        wr_idx = 0;
        send(img, 1'b0);
        finish_img(1'b1);
        chk("recov_last_addr", {16'b0, last_addr}, 32'h0002);
        chk("recov_last_data", {16'b0, last_data}, 32'hBEEF);

        // Reset after the high byte of word 2.
        exp_q.delete();
        exp_q.push_back({16'h0000, 16'h1234});
        do_start();
        img = '{8'h00, 8'h03, 8'h12, 8'h34, 8'h56};
        send(img, 1'b0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        chk("rst_pending", exp_q.size(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_idle", {31'b0, in_ready}, 32'd0);
        img = '{8'h00, 8'h01, 8'hCA, 8'hFE};
        build_exp(img);
        wr_idx = 0;
        do_start();
        send(img, 1'b0);
        finish_img(1'b1);
        chk("fresh_addr", {16'b0, last_addr}, 32'h0000);
        chk("fresh_data", {16'b0, last_data}, 32'hCAFE);

        // Second load from DONE.
        img = '{8'h00, 8'h01, 8'hAA, 8'hAA};
        build_exp(img);
        wr_idx = 0;
        do_start();
        #1;
        chk("reload_done", {31'b0, done}, 32'd0);
        chk("reload_hold", {31'b0, core_hold}, 32'd1);
        send(img, 1'b0);
        finish_img(1'b1);
        chk("reload_addr", {16'b0, last_addr}, 32'h0000);
        chk("reload_data", {16'b0, last_data}, 32'hAAAA);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
